// File: rtl/cam_entry_manager_if.sv
// Signal bundle for cam_entry_manager: request/response channels, the CAM write and compare
// port, and occupancy status. Build macro CAM_ENTRY_MANAGER_FLUSH_EN adds flush_req/flush_busy.
interface cam_entry_manager_if #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned SLICE_WIDTH = 4
);
  localparam int unsigned SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_op;
  logic [DATA_WIDTH-1:0]  req_key;
  logic [SLICE_COUNT-1:0] req_mask;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ADDR_WIDTH-1:0]  rsp_addr;
  logic [1:0]             rsp_status;
  logic [ADDR_WIDTH-1:0]  cam_write_addr;
  logic [DATA_WIDTH-1:0]  cam_write_data;
  logic                   cam_write_delete;
  logic                   cam_write_enable;
  logic [SLICE_COUNT-1:0] cam_select_mask;
  logic                   cam_write_busy;
  logic [DATA_WIDTH-1:0]  cam_compare_data;
  logic                   cam_match;
  logic [ADDR_WIDTH-1:0]  cam_match_addr;
  logic [ADDR_WIDTH:0]    occupancy;
  logic                   full;
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
  logic                   flush_req;
  logic                   flush_busy;
`endif

  // Manager side
  modport slave (
    input  req_valid, req_op, req_key, req_mask, rsp_ready,
    input  cam_write_busy, cam_match, cam_match_addr,
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
    input  flush_req,
    output flush_busy,
`endif
    output req_ready, rsp_valid, rsp_addr, rsp_status,
    output cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
    output cam_select_mask, cam_compare_data, occupancy, full
  );

  // Environment side: request source, response sink and CAM
  modport master (
    output req_valid, req_op, req_key, req_mask, rsp_ready,
    output cam_write_busy, cam_match, cam_match_addr,
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
    output flush_req,
    input  flush_busy,
`endif
    input  req_ready, rsp_valid, rsp_addr, rsp_status,
    input  cam_write_addr, cam_write_data, cam_write_delete, cam_write_enable,
    input  cam_select_mask, cam_compare_data, occupancy, full
  );
endinterface

// File: rtl/cam_entry_manager.sv
// Initiator-side CAM entry manager: duplicate check via compare, lowest-free allocation from a
// bitmap, CAM write/delete with write_busy handshake, valid/ready response.
// Optional build macro CAM_ENTRY_MANAGER_FLUSH_EN adds a flush walk that deletes every entry.
module cam_entry_manager #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned SLICE_WIDTH = 4,
  parameter int unsigned CMP_LATENCY = 2
) (
  input logic                clk,
  input logic                rst_n,
  cam_entry_manager_if.slave bus
);
  localparam int unsigned SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int unsigned ENTRIES     = 1 << ADDR_WIDTH;
  localparam int unsigned OCC_W       = ADDR_WIDTH + 1;
  localparam int unsigned CNT_W       = (CMP_LATENCY > 1) ? $clog2(CMP_LATENCY) : 1;

  localparam logic [1:0] StatOk       = 2'd0;
  localparam logic [1:0] StatDup      = 2'd1;
  localparam logic [1:0] StatFull     = 2'd2;
  localparam logic [1:0] StatNotFound = 2'd3;

`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
  typedef enum logic [2:0] {StIdle, StCmp, StDecide, StWrite, StSettle, StResp, StFlush} state_e;
`else
  typedef enum logic [2:0] {StIdle, StCmp, StDecide, StWrite, StSettle, StResp} state_e;
`endif

  state_e                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_op;
  logic [DATA_WIDTH-1:0]  r_key;
  logic [SLICE_COUNT-1:0] r_mask;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ENTRIES-1:0]     r_bitmap;
  logic [OCC_W-1:0]       r_occ;
  logic                   r_full;
  logic                   r_req_ready;
  logic                   r_rsp_valid;
  logic [ADDR_WIDTH-1:0]  r_rsp_addr;
  logic [1:0]             r_rsp_status;
  logic [ADDR_WIDTH-1:0]  r_wr_addr;
  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   r_wr_del;
  logic                   r_wr_en;
  logic [SLICE_COUNT-1:0] r_sel_mask;
  logic [DATA_WIDTH-1:0]  r_cmp_data;
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
  logic                   r_flushing;
  logic                   r_flush_busy;
  logic [ADDR_WIDTH-1:0]  r_faddr;
`endif
  logic [ADDR_WIDTH-1:0]  w_free_addr;

  // Lowest-index free entry; only consulted when the table is not full
  always_comb begin
    w_free_addr = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (!r_bitmap[i]) w_free_addr = ADDR_WIDTH'(i);
    end
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_op         <= 1'b0;
      r_key        <= '0;
      r_mask       <= '0;
      r_addr       <= '0;
      r_bitmap     <= '0;
      r_occ        <= '0;
      r_full       <= 1'b0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_addr   <= '0;
      r_rsp_status <= StatOk;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_del     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_sel_mask   <= '0;
      r_cmp_data   <= '0;
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
      r_flushing   <= 1'b0;
      r_flush_busy <= 1'b0;
      r_faddr      <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
          if (bus.flush_req) begin
            r_req_ready  <= 1'b0;
            r_flush_busy <= 1'b1;
            r_flushing   <= 1'b1;
            r_faddr      <= '0;
            r_state      <= StFlush;
          end else
`endif
          if (bus.req_valid && r_req_ready) begin
            r_op        <= bus.req_op;
            r_key       <= bus.req_key;
            r_mask      <= bus.req_mask;
            r_cmp_data  <= bus.req_key;
            r_req_ready <= 1'b0;
            r_cnt       <= '0;
            r_state     <= StCmp;
          end
        end
        StCmp: begin
          if (r_cnt == CNT_W'(CMP_LATENCY - 1)) r_state <= StDecide;
          else r_cnt <= r_cnt + 1'b1;
        end
        StDecide: begin
          // Match result is valid now: CMP_LATENCY cycles after compare_data was driven
          if (!r_op) begin
            if (bus.cam_match) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= StatDup;
              r_rsp_addr   <= bus.cam_match_addr;
              r_state      <= StResp;
            end else if (r_full) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= StatFull;
              r_rsp_addr   <= '0;
              r_state      <= StResp;
            end else begin
              r_addr     <= w_free_addr;
              r_wr_addr  <= w_free_addr;
              r_wr_data  <= r_key;
              r_sel_mask <= r_mask;
              r_wr_del   <= 1'b0;
              r_wr_en    <= 1'b1;
              r_state    <= StWrite;
            end
          end else begin
            if (!bus.cam_match) begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= StatNotFound;
              r_rsp_addr   <= '0;
              r_state      <= StResp;
            end else begin
              r_addr     <= bus.cam_match_addr;
              r_wr_addr  <= bus.cam_match_addr;
              r_wr_data  <= r_key;
              r_sel_mask <= '1;
              r_wr_del   <= 1'b1;
              r_wr_en    <= 1'b1;
              r_state    <= StWrite;
            end
          end
        end
        StWrite: begin
          if (!bus.cam_write_busy) begin
            // Write accepted this cycle; bitmap tracks what the CAM now holds
            if (r_wr_del) begin
              if (r_bitmap[r_wr_addr]) begin
                r_bitmap[r_wr_addr] <= 1'b0;
                r_occ               <= r_occ - 1'b1;
                r_full              <= 1'b0;
              end
            end else if (!r_bitmap[r_wr_addr]) begin
              r_bitmap[r_wr_addr] <= 1'b1;
              r_occ               <= r_occ + 1'b1;
              r_full              <= (r_occ == OCC_W'(ENTRIES - 1));
            end
            r_wr_en    <= 1'b0;
            r_wr_del   <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_sel_mask <= '0;
            r_state    <= StSettle;
          end
        end
        StSettle: begin
          if (!bus.cam_write_busy) begin
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
            if (r_flushing) begin
              if (r_faddr == '1) begin
                r_flushing   <= 1'b0;
                r_flush_busy <= 1'b0;
                r_req_ready  <= 1'b1;
                r_state      <= StIdle;
              end else begin
                r_faddr <= r_faddr + 1'b1;
                r_state <= StFlush;
              end
            end else
`endif
            begin
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= StatOk;
              r_rsp_addr   <= r_addr;
              r_state      <= StResp;
            end
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_addr   <= '0;
            r_rsp_status <= StatOk;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end
        end
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
        StFlush: begin
          // Occupied entries get a full-mask delete; free ones are skipped in one cycle
          if (r_bitmap[r_faddr]) begin
            r_addr     <= r_faddr;
            r_wr_addr  <= r_faddr;
            r_wr_data  <= '0;
            r_sel_mask <= '1;
            r_wr_del   <= 1'b1;
            r_wr_en    <= 1'b1;
            r_state    <= StWrite;
          end else if (r_faddr == '1) begin
            r_flushing   <= 1'b0;
            r_flush_busy <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= StIdle;
          end else begin
            r_faddr <= r_faddr + 1'b1;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.req_ready        = r_req_ready;
  assign bus.rsp_valid        = r_rsp_valid;
  assign bus.rsp_addr         = r_rsp_addr;
  assign bus.rsp_status       = r_rsp_status;
  assign bus.cam_write_addr   = r_wr_addr;
  assign bus.cam_write_data   = r_wr_data;
  assign bus.cam_write_delete = r_wr_del;
  assign bus.cam_write_enable = r_wr_en;
  assign bus.cam_select_mask  = r_sel_mask;
  assign bus.cam_compare_data = r_cmp_data;
  assign bus.occupancy        = r_occ;
  assign bus.full             = r_full;
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
  assign bus.flush_busy       = r_flush_busy;
`endif
endmodule

// File: tb/tb_cam_entry_manager.sv
// Self-checking bench for cam_entry_manager: behavioural CAM, key-to-address reference model,
// directed plan steps followed by randomized insert/delete traffic.
`timescale 1ns/1ps
module tb_cam_entry_manager;
  localparam int unsigned DW  = 64;
  localparam int unsigned AW  = 5;
  localparam int unsigned SW  = 4;
  localparam int unsigned LAT = 2;
  localparam int unsigned ENT = 1 << AW;
  localparam int unsigned SC  = (DW + SW - 1) / SW;

  localparam logic [1:0] ST_OK = 2'd0, ST_DUP = 2'd1, ST_FULL = 2'd2, ST_NF = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_entry_manager_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW)) bus ();

  cam_entry_manager #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .SLICE_WIDTH(SW),
    .CMP_LATENCY(LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural CAM: stores what the DUT writes, answers compares LAT cycles later
  logic [DW-1:0]  cam_key [ENT];
  logic [ENT-1:0] cam_vld;
  logic [DW-1:0]  cmp_d1, cmp_d2;
  int unsigned    wr_cnt = 0;
  logic [AW-1:0]  wr_addr;
  logic           wr_del;
  logic [DW-1:0]  wr_data;
  logic [SC-1:0]  wr_mask;
  logic           m_hit;
  logic [AW-1:0]  m_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vld <= '0;
      cmp_d1  <= '0;
      cmp_d2  <= '0;
    end else begin
      cmp_d1 <= bus.cam_compare_data;
      cmp_d2 <= cmp_d1;
      if (bus.cam_write_enable && !bus.cam_write_busy) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= bus.cam_write_addr;
        wr_del  <= bus.cam_write_delete;
        wr_data <= bus.cam_write_data;
        wr_mask <= bus.cam_select_mask;
        if (bus.cam_write_delete) cam_vld[bus.cam_write_addr] <= 1'b0;
        else begin
          cam_vld[bus.cam_write_addr] <= 1'b1;
          cam_key[bus.cam_write_addr] <= bus.cam_write_data;
        end
      end
    end
  end

  always_comb begin
    m_hit  = 1'b0;
    m_addr = '0;
    for (int i = int'(ENT) - 1; i >= 0; i--) begin
      if (cam_vld[i] && (cam_key[i] === cmp_d2)) begin
        m_hit  = 1'b1;
        m_addr = AW'(i);
      end
    end
  end
  assign bus.cam_match      = m_hit;
  assign bus.cam_match_addr = m_addr;

  // Reference model: which key lives at which address
  int         ref_map [logic [63:0]];
  bit [ENT-1:0] ref_used;

  function automatic int lowest_free();
    for (int i = 0; i < int'(ENT); i++) if (!ref_used[i]) return i;
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input logic op, input logic [DW-1:0] key, input logic [SC-1:0] mask,
                        input int busy_hold, input int rdy_delay);
    logic [1:0]    exp_st;
    logic [AW-1:0] exp_addr;
    logic [SC-1:0] exp_mask;
    bit            exp_wr;
    bit            en_seen;
    int            guard;
    int            en_cycles;
    int            a;
    int unsigned   w0;
    exp_wr   = 1'b0;
    exp_addr = '0;
    exp_mask = op ? {SC{1'b1}} : mask;
    if (!op) begin
      if (ref_map.exists(key)) begin
        exp_st = ST_DUP; exp_addr = AW'(ref_map[key]);
      end else if (ref_map.num() == int'(ENT)) begin
        exp_st = ST_FULL;
      end else begin
        a = lowest_free();
        exp_st = ST_OK; exp_addr = AW'(a); exp_wr = 1'b1;
        ref_map[key] = a; ref_used[a] = 1'b1;
      end
    end else begin
      if (ref_map.exists(key)) begin
        a = ref_map[key];
        exp_st = ST_OK; exp_addr = AW'(a); exp_wr = 1'b1;
        ref_map.delete(key); ref_used[a] = 1'b0;
      end else begin
        exp_st = ST_NF;
      end
    end

    guard = 0;
    while (!bus.req_ready && guard < 200) begin @(negedge clk); guard++; end
    check("req_ready", bus.req_ready, 1'b1);
    w0 = wr_cnt;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_key = key; bus.req_mask = mask;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("req_ready_busy", bus.req_ready, 1'b0);

    en_seen = 1'b0;
    guard = 0;
    while (!bus.rsp_valid && guard < 100) begin
      if (bus.cam_write_enable && !en_seen) begin
        en_seen = 1'b1;
        if (busy_hold > 0) begin
          bus.cam_write_busy = 1'b1;
          en_cycles = 0;
          for (int i = 0; i < busy_hold; i++) begin
            @(negedge clk);
            if (bus.cam_write_enable) en_cycles++;
          end
          bus.cam_write_busy = 1'b0;
          check("enable_held", en_cycles, busy_hold);
        end
      end
      @(negedge clk);
      guard++;
    end
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_status", bus.rsp_status, exp_st);
    check("rsp_addr", bus.rsp_addr, exp_addr);
    check("write_seen", en_seen, exp_wr);
    check("write_count", wr_cnt - w0, exp_wr);
    if (exp_wr) begin
      check("wr_addr", wr_addr, exp_addr);
      check("wr_delete", wr_del, op);
      check("wr_data", wr_data, key);
      check("wr_mask", wr_mask, exp_mask);
    end
    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk);
      check("rsp_valid_hold", bus.rsp_valid, 1'b1);
      check("rsp_status_hold", bus.rsp_status, exp_st);
      check("rsp_addr_hold", bus.rsp_addr, exp_addr);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_drop", bus.rsp_valid, 1'b0);
    check("req_ready_back", bus.req_ready, 1'b1);
    check("occupancy", bus.occupancy, ref_map.num());
    check("full", bus.full, ref_map.num() == int'(ENT));
  endtask

  logic [DW-1:0] keys [ENT];
  logic [DW-1:0] rk;
  int            guard_m;
  int unsigned   w_m;

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_key = '0; bus.req_mask = '0;
    bus.rsp_ready = 1'b0; bus.cam_write_busy = 1'b0;
`ifdef CAM_ENTRY_MANAGER_FLUSH_EN
    bus.flush_req = 1'b0;
`endif
    ref_used = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_occupancy", bus.occupancy, 0);
    check("rst_full", bus.full, 1'b0);
    check("rst_wr_en", bus.cam_write_enable, 1'b0);
    check("rst_cmp_data", bus.cam_compare_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First insert, then the same key again
    keys[0] = 64'hDEADBEEF_00000001;
    for (int i = 1; i < int'(ENT); i++) keys[i] = {32'hA5A5_0000 + 32'(i), 32'($urandom())};
    run_op(1'b0, keys[0], 16'hFFFF, 0, 0);
    run_op(1'b0, keys[0], 16'hFFFF, 0, 0);
    // Fill the table, then overflow
    for (int i = 1; i < int'(ENT); i++) run_op(1'b0, keys[i], SC'($urandom()), 0, 0);
    run_op(1'b0, 64'h1234_5678_9ABC_DEF0, 16'hFFFF, 0, 0);
    // Delete addr 5, its slot is reused
    run_op(1'b1, keys[5], 16'h0000, 0, 0);
    run_op(1'b0, 64'hCAFE_F00D_0000_0005, 16'h00FF, 0, 0);
    // Long write_busy stall plus slow response accept
    run_op(1'b1, keys[7], 16'h0000, 16, 3);

    // Random traffic over a mix of table keys and a small fresh pool
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 0) rk = keys[$urandom_range(0, ENT - 1)];
      else rk = 64'h5555_0000_0000_0000 + 64'($urandom_range(0, 7));
      run_op(1'($urandom_range(0, 1)), rk, SC'($urandom()), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    // Ensure a write will happen, then reset while settling
    if (ref_map.num() == int'(ENT)) run_op(1'b1, keys[0], 16'h0000, 0, 0);
    guard_m = 0;
    while (!bus.req_ready && guard_m < 200) begin @(negedge clk); guard_m++; end
    w_m = wr_cnt;
    bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_key = 64'h7777_0000_1111_2222;
    bus.req_mask = 16'hFFFF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard_m = 0;
    while (wr_cnt == w_m && guard_m < 100) begin @(negedge clk); guard_m++; end
    check("settle_write_done", wr_cnt - w_m, 1);
    bus.cam_write_busy = 1'b1;
    @(negedge clk);
    check("settle_no_rsp", bus.rsp_valid, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", bus.req_ready, 1'b1);
    check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rst_occupancy", bus.occupancy, 0);
    check("mid_rst_full", bus.full, 1'b0);
    check("mid_rst_wr_en", bus.cam_write_enable, 1'b0);
    check("mid_rst_status", bus.rsp_status, 0);
    bus.cam_write_busy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
    ref_map.delete();
    ref_used = '0;
    run_op(1'b0, 64'h0BAD_CAFE_0000_0042, 16'hFFFF, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
